// File: rtl/nr_mem_pkg.sv
// nr_mem_pkg
//   Shared definitions for the nanoRisk memory-side helpers: the default
//   address and data widths of the data/instruction memory, and the state
//   encoding of the program loader.
package nr_mem_pkg;

  localparam int NR_ADDR_W = 4;
  localparam int NR_DATA_W = 8;

  // The numeric values are fixed so that a state register probed on a
  // debug bus reads the same codes in every build.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    VERIFY_RD  = 3'd2,
    VERIFY_CMP = 3'd3,
    DONE       = 3'd4,
    ERROR      = 3'd5
  } nr_ldr_state_t;

endpackage

// File: rtl/nr_checksum_acc.sv
// nr_checksum_acc
//   Running modulo-2**DATA_W byte sum. The loader uses one instance to
//   sum the bytes it writes and a second one to sum the bytes it reads
//   back during verification.
// Ports:
//   clk     : system clock
//   clr     : asynchronous active-high reset, sum returns to 0
//   clear_i : synchronous clear, takes priority over en_i
//   en_i    : add data_i to the sum on this clock edge
//   data_i  : byte to accumulate
//   sum_o   : current registered sum
module nr_checksum_acc
  import nr_mem_pkg::*;
#(
  parameter int DATA_W = NR_DATA_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] sum_o
);

  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] sum_d;

  // Clear wins over accumulate so a new image always starts from zero,
  // even if the caller happens to pulse both in the same cycle.
  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = sum_q + data_i;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/nr_program_loader.sv
// nr_program_loader
//   Writes a byte stream arriving on a valid/ready handshake into
//   consecutive memory addresses, optionally reads the image back and
//   checks it against the running checksum, and keeps the CPU stalled
//   until the image is loaded (and verified).
// Ports:
//   clk, clr              : clock, asynchronous active-high reset
//   start                 : begin a load (honoured only when not busy)
//   s_valid/s_ready       : stream handshake
//   s_data/s_last         : stream byte and end-of-image marker
//   wr_en/wr_addr/wr_data : memory write port
//   rd_en/rd_addr/rd_data : memory read port (data one edge after rd_en)
//   busy                  : loading or verifying
//   done / err            : image good / verify mismatch, held until start
//   cpu_hold              : processor stall, released only in DONE
//   count                 : bytes written for the current image
//   checksum              : modulo sum of the written bytes
module nr_program_loader
  import nr_mem_pkg::*;
#(
  parameter int ADDR_W = NR_ADDR_W,
  parameter int DATA_W = NR_DATA_W,
  parameter int DEPTH  = 2**ADDR_W,
  parameter int VERIFY = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  nr_ldr_state_t     state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] vptr_q, vptr_d;

  logic              sumClear;
  logic              vsumEn;
  logic [DATA_W-1:0] wrSum;
  logic [DATA_W-1:0] vSum;
  logic [DATA_W-1:0] vSumNext;
  logic [ADDR_W:0]   vptrInc;

  // The read-back sum including the word on rd_data this cycle; the final
  // comparison must include the last word before it is registered.
  assign vSumNext = vSum + rd_data;
  assign vptrInc  = {1'b0, vptr_q} + (ADDR_W+1)'(1);

  nr_checksum_acc #(.DATA_W(DATA_W)) u_wrSum (
    .clk     (clk),
    .clr     (clr),
    .clear_i (sumClear),
    .en_i    (wr_en),
    .data_i  (s_data),
    .sum_o   (wrSum)
  );

  nr_checksum_acc #(.DATA_W(DATA_W)) u_vSum (
    .clk     (clk),
    .clr     (clr),
    .clear_i (sumClear),
    .en_i    (vsumEn),
    .data_i  (rd_data),
    .sum_o   (vSum)
  );

  // Next-state and handshake/memory strobes. The write strobe follows
  // s_valid combinationally so a byte is written in the cycle it is
  // accepted; the image ends on s_last or when the last slot is filled,
  // whichever comes first.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    vptr_d   = vptr_q;
    sumClear = 1'b0;
    vsumEn   = 1'b0;
    s_ready  = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d  = LOAD;
          count_d  = '0;
          vptr_d   = '0;
          sumClear = 1'b1;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          wr_en   = 1'b1;
          count_d = count_q + (ADDR_W+1)'(1);
          if (s_last || (count_q == LAST_IDX)) begin
            state_d = (VERIFY != 0) ? VERIFY_RD : DONE;
          end
        end
      end
      VERIFY_RD: begin
        rd_en   = 1'b1;
        state_d = VERIFY_CMP;
      end
      VERIFY_CMP: begin
        vsumEn = 1'b1;
        vptr_d = vptr_q + ADDR_W'(1);
        if (vptrInc == count_q) begin
          state_d = (vSumNext == wrSum) ? DONE : ERROR;
        end else begin
          state_d = VERIFY_RD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and pointer registers; reset abandons any load in flight, and
  // because the write strobe is decoded from state_q it drops the moment
  // clr rises.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      count_q <= '0;
      vptr_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      vptr_q  <= vptr_d;
    end
  end

  // Addresses and data are forced to zero when their strobe is low so the
  // memory buses stay quiet outside real transfers.
  assign wr_addr  = wr_en ? count_q[ADDR_W-1:0] : '0;
  assign wr_data  = wr_en ? s_data : '0;
  assign rd_addr  = rd_en ? vptr_q : '0;

  assign busy     = (state_q == LOAD) || (state_q == VERIFY_RD) ||
                    (state_q == VERIFY_CMP);
  assign done     = (state_q == DONE);
  assign err      = (state_q == ERROR);
  assign cpu_hold = (state_q != DONE);
  assign count    = count_q;
  assign checksum = wrSum;

endmodule

// File: tb/tb_nr_program_loader.sv
// tb_nr_program_loader
//   Self-checking bench for nr_program_loader with a behavioural memory
//   and a transaction-level reference model of the loader.
module tb_nr_program_loader;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data = 8'h00;
  logic       busy;
  logic       done;
  logic       err;
  logic       cpu_hold;
  logic [4:0] count;
  logic [7:0] checksum;

  int errors = 0;
  int checks = 0;
  int writeCount = 0;

  logic [7:0] mem [16];
  bit         corruptEn = 1'b0;
  int         corruptAddr = 0;
  logic [7:0] img [$];

  // Reference model state: loading flag, bytes taken, modulo sum, cycles
  // of read-back still to run, and the sticky result flags.
  bit mLoading = 1'b0;
  int mCount = 0;
  int mSum = 0;
  int mVerifyLeft = 0;
  bit mDone = 1'b0;
  bit mErr = 1'b0;

  always #5 clk = ~clk;

  nr_program_loader dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_hold (cpu_hold),
    .count    (count),
    .checksum (checksum)
  );

  // Behavioural memory: writes on the rising edge, reads on the falling
  // edge, with an optional single corrupted address on the read side.
  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always @(negedge clk) begin
    if (rd_en) begin
      if (corruptEn && (int'(rd_addr) == corruptAddr)) rd_data <= mem[rd_addr] + 8'd1;
      else rd_data <= mem[rd_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: one image is a run of accepted bytes ending on s_last
  // or after DEPTH bytes, followed by two cycles per byte of read-back.
  initial begin
    forever begin
      @(posedge clk or posedge clr);
      if (clr) begin
        mLoading = 1'b0; mCount = 0; mSum = 0; mVerifyLeft = 0;
        mDone = 1'b0; mErr = 1'b0;
      end else if (mLoading) begin
        if (s_valid) begin
          mSum = (mSum + int'(s_data)) % 256;
          mCount++;
          if (s_last || mCount == DEPTH) begin
            mLoading = 1'b0;
            mVerifyLeft = 2 * mCount;
          end
        end
      end else if (mVerifyLeft > 0) begin
        mVerifyLeft--;
        if (mVerifyLeft == 0) begin
          if (corruptEn && corruptAddr < mCount) mErr = 1'b1;
          else mDone = 1'b1;
        end
      end else if (start) begin
        mLoading = 1'b1; mCount = 0; mSum = 0; mDone = 1'b0; mErr = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, on the falling edge.
  initial begin
    bit expWr, expRd;
    int expRdAddr;
    forever begin
      @(negedge clk);
      if (!clr) begin
        expWr = mLoading && s_valid;
        expRd = (mVerifyLeft > 0) && (mVerifyLeft % 2 == 0);
        expRdAddr = expRd ? (mCount - mVerifyLeft / 2) : 0;
        if (wr_en) writeCount++;
        checkOutput("wr_en", wr_en, expWr);
        checkOutput("wr_addr", wr_addr, expWr ? mCount : 0);
        checkOutput("wr_data", wr_data, expWr ? s_data : 8'h00);
        checkOutput("rd_en", rd_en, expRd);
        checkOutput("rd_addr", rd_addr, expRdAddr);
        checkOutput("wr_rd_excl", wr_en && rd_en, 0);
        checkOutput("s_ready", s_ready, mLoading);
        checkOutput("busy", busy, mLoading || (mVerifyLeft > 0));
        checkOutput("done", done, mDone);
        checkOutput("err", err, mErr);
        checkOutput("cpu_hold", cpu_hold, !mDone);
        checkOutput("count", count, mCount);
        checkOutput("checksum", checksum, mSum);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit v, input logic [7:0] d, input bit l, input bit st);
    s_valid = v; s_data = d; s_last = l; start = st;
    tick();
  endtask

  // Offers every byte of img, with up to maxGap idle cycles before each;
  // stray start pulses in early gaps must be ignored by the loader.
  task automatic sendImage(input bit withLast, input int maxGap);
    for (int i = 0; i < img.size(); i++) begin
      int g;
      g = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
      repeat (g) applyStimulus(1'b0, 8'($urandom), 1'b0, (i < 8) && ($urandom_range(0, 4) == 0));
      applyStimulus(1'b1, img[i], withLast && (i == img.size() - 1), 1'b0);
    end
    s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
  endtask

  task automatic waitFinish(output int cycles);
    cycles = 0;
    while (!(done || err) && cycles < 300) begin
      tick();
      cycles++;
    end
    checkOutput("finish_timeout", cycles < 300, 1);
  endtask

  initial begin
    int cyc;
    // Reset state while clr is held from time zero.
    #3;
    checkOutput("rst_cpu_hold", cpu_hold, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_wr_en", wr_en, 0);
    tick();
    clr = 1'b0;
    tick();

    // Basic 4-byte image with read-back.
    $display("[TB] basic load");
    img = '{8'h11, 8'h22, 8'h33, 8'h44};
    writeCount = 0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    sendImage(1'b1, 0);
    checkOutput("basic_count", count, 4);
    checkOutput("basic_checksum", checksum, 8'hAA);
    waitFinish(cyc);
    checkOutput("basic_verify_cycles", cyc, 8);
    checkOutput("basic_done", done, 1);
    checkOutput("basic_hold", cpu_hold, 0);
    checkOutput("basic_writes", writeCount, 4);
    checkOutput("basic_mem0", mem[0], 8'h11);
    checkOutput("basic_mem3", mem[3], 8'h44);

    // Gaps in s_valid: only valid cycles write, addresses stay contiguous.
    $display("[TB] gaps");
    writeCount = 0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h05, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h99, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h06, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h99, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h07, 1'b1, 1'b0);
    s_valid = 1'b0; s_last = 1'b0;
    checkOutput("gap_writes", writeCount, 3);
    checkOutput("gap_count", count, 3);
    checkOutput("gap_checksum", checksum, 8'h12);
    waitFinish(cyc);
    checkOutput("gap_done", done, 1);

    // Full image: 20 bytes offered, no s_last, only 16 taken.
    $display("[TB] full");
    img.delete();
    for (int i = 1; i <= 20; i++) img.push_back(8'(i));
    writeCount = 0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    sendImage(1'b0, 0);
    checkOutput("full_writes", writeCount, 16);
    checkOutput("full_count", count, 16);
    checkOutput("full_ready", s_ready, 0);
    checkOutput("full_checksum", checksum, 8'h88);
    waitFinish(cyc);
    checkOutput("full_done", done, 1);

    // Restart from DONE clears the flags and reloads.
    $display("[TB] restart");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("restart_done", done, 0);
    checkOutput("restart_hold", cpu_hold, 1);
    checkOutput("restart_count", count, 0);
    img = '{8'hA0, 8'hB0, 8'hC0};
    sendImage(1'b1, 1);
    waitFinish(cyc);
    checkOutput("restart_done2", done, 1);

    // Read-back corruption at address 2.
    $display("[TB] verify failure");
    corruptEn = 1'b1; corruptAddr = 2;
    img = '{8'h11, 8'h22, 8'h33, 8'h44};
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    sendImage(1'b1, 0);
    waitFinish(cyc);
    checkOutput("corrupt_err", err, 1);
    checkOutput("corrupt_done", done, 0);
    checkOutput("corrupt_hold", cpu_hold, 1);
    corruptEn = 1'b0;

    // Reset in the middle of a load, with a third byte on the bus.
    $display("[TB] mid-load reset");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h6B, 1'b0, 1'b0);
    s_valid = 1'b1; s_data = 8'h7C;
    #2;
    clr = 1'b1;
    #1;
    checkOutput("midrst_wr_en", wr_en, 0);
    checkOutput("midrst_count", count, 0);
    checkOutput("midrst_checksum", checksum, 0);
    checkOutput("midrst_hold", cpu_hold, 1);
    checkOutput("midrst_ready", s_ready, 0);
    checkOutput("midrst_busy", busy, 0);
    tick();
    clr = 1'b0; s_valid = 1'b0;
    tick();
    img = '{8'hE1, 8'hE2, 8'hE3};
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    sendImage(1'b1, 0);
    checkOutput("reload_mem0", mem[0], 8'hE1);
    waitFinish(cyc);
    checkOutput("reload_done", done, 1);

    // Randomised images with gaps, optional s_last and random corruption.
    $display("[TB] random");
    for (int it = 0; it < 12; it++) begin
      int len;
      bit withLast;
      len = int'($urandom_range(1, 20));
      withLast = (len < 16) || ($urandom_range(0, 1) == 1);
      img.delete();
      for (int i = 0; i < len; i++) img.push_back(8'($urandom));
      corruptEn = ($urandom_range(0, 3) == 0);
      corruptAddr = int'($urandom_range(0, 15));
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      sendImage(withLast, 3);
      waitFinish(cyc);
      repeat (2) tick();
      corruptEn = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog");
  end

endmodule
